// File: rtl/instruction_encode_serial.sv
// instruction_encode_serial
// Byte-serial RV32I instruction encoder, the inverse of the instruction decoder.
// A 12-byte frame (5-char mnemonic, rd, rs1, rs2, 32-bit little-endian imm)
// arrives over a valid/ready byte stream. The encoded word leaves on a
// valid/ready output together with an error flag.
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_byte carries a frame byte this cycle
//   in_ready   encoder accepts a byte this cycle (COLLECT only)
//   in_byte    frame byte
//   out_valid  out_instr/out_err are valid (OUTPUT only)
//   out_ready  consumer accepts the output word
//   out_instr  encoded instruction (NOP_WORD on rejection)
//   out_err    frame rejected
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and ready is low.
// Valid never depends on ready.
module instruction_encode_serial #(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    typedef enum logic [1:0] {COLLECT, ENCODE, OUTPUT} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_t;

    state_t state;
    state_t state_next;

    logic [3:0]  count;
    logic [39:0] mnem;
    logic [7:0]  rd_b;
    logic [7:0]  rs1_b;
    logic [7:0]  rs2_b;
    logic [31:0] imm;

    logic        xfer;
    fmt_t        fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        known;
    logic        reg_bad;
    logic [31:0] enc_word;

    function automatic logic [7:0] fold_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    endfunction

    assign xfer = in_valid && in_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= COLLECT;
        else       state <= state_next;
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && count == 4'd11) state_next = ENCODE;
            end
            ENCODE:  state_next = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    // Frame capture. Mnemonic bytes shift in so byte 0 ends up in the MSBs,
    // which lets the decode below compare directly against string literals.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 4'd0;
            mnem  <= 40'd0;
            rd_b  <= 8'd0;
            rs1_b <= 8'd0;
            rs2_b <= 8'd0;
            imm   <= 32'd0;
        end else if (xfer) begin
            count <= (count == 4'd11) ? 4'd0 : count + 4'd1;
            case (count)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4: mnem <= {mnem[31:0], fold_upper(in_byte)};
                4'd5:  rd_b  <= in_byte;
                4'd6:  rs1_b <= in_byte;
                4'd7:  rs2_b <= in_byte;
                4'd8:  imm[7:0]   <= in_byte;
                4'd9:  imm[15:8]  <= in_byte;
                4'd10: imm[23:16] <= in_byte;
                default: imm[31:24] <= in_byte;
            endcase
        end
    end

    // Mnemonic lookup
    always_comb begin
        fmt    = F_R;
        opcode = 7'h33;
        f3     = 3'd0;
        f7     = 7'h00;
        known  = 1'b1;
        case (mnem)
            "ADD  ": ;
            "SUB  ": f7 = 7'h20;
            "SLL  ": f3 = 3'd1;
            "SLT  ": f3 = 3'd2;
            "SLTU ": f3 = 3'd3;
            "XOR  ": f3 = 3'd4;
            "SRL  ": f3 = 3'd5;
            "SRA  ": begin f3 = 3'd5; f7 = 7'h20; end
            "OR   ": f3 = 3'd6;
            "AND  ": f3 = 3'd7;
            "ADDI ": begin fmt = F_I;  opcode = 7'h13; end
            "SLTI ": begin fmt = F_I;  opcode = 7'h13; f3 = 3'd2; end
            "SLTIU": begin fmt = F_I;  opcode = 7'h13; f3 = 3'd3; end
            "XORI ": begin fmt = F_I;  opcode = 7'h13; f3 = 3'd4; end
            "ORI  ": begin fmt = F_I;  opcode = 7'h13; f3 = 3'd6; end
            "ANDI ": begin fmt = F_I;  opcode = 7'h13; f3 = 3'd7; end
            "SLLI ": begin fmt = F_SH; opcode = 7'h13; f3 = 3'd1; end
            "SRLI ": begin fmt = F_SH; opcode = 7'h13; f3 = 3'd5; end
            "SRAI ": begin fmt = F_SH; opcode = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            "LB   ": begin fmt = F_I;  opcode = 7'h03; end
            "LH   ": begin fmt = F_I;  opcode = 7'h03; f3 = 3'd1; end
            "LW   ": begin fmt = F_I;  opcode = 7'h03; f3 = 3'd2; end
            "LBU  ": begin fmt = F_I;  opcode = 7'h03; f3 = 3'd4; end
            "LHU  ": begin fmt = F_I;  opcode = 7'h03; f3 = 3'd5; end
            "JALR ": begin fmt = F_I;  opcode = 7'h67; end
            "SB   ": begin fmt = F_S;  opcode = 7'h23; end
            "SH   ": begin fmt = F_S;  opcode = 7'h23; f3 = 3'd1; end
            "SW   ": begin fmt = F_S;  opcode = 7'h23; f3 = 3'd2; end
            "BEQ  ": begin fmt = F_B;  opcode = 7'h63; end
            "BNE  ": begin fmt = F_B;  opcode = 7'h63; f3 = 3'd1; end
            "BLT  ": begin fmt = F_B;  opcode = 7'h63; f3 = 3'd4; end
            "BGE  ": begin fmt = F_B;  opcode = 7'h63; f3 = 3'd5; end
            "BLTU ": begin fmt = F_B;  opcode = 7'h63; f3 = 3'd6; end
            "BGEU ": begin fmt = F_B;  opcode = 7'h63; f3 = 3'd7; end
            "LUI  ": begin fmt = F_U;  opcode = 7'h37; end
            "AUIPC": begin fmt = F_U;  opcode = 7'h17; end
            "JAL  ": begin fmt = F_J;  opcode = 7'h6F; end
            default: known = 1'b0;
        endcase
    end

    // Field assembly; only register fields the format uses are range-checked
    always_comb begin
        reg_bad  = 1'b0;
        enc_word = 32'd0;
        case (fmt)
            F_R: begin
                reg_bad  = (|rd_b[7:5]) || (|rs1_b[7:5]) || (|rs2_b[7:5]);
                enc_word = {f7, rs2_b[4:0], rs1_b[4:0], f3, rd_b[4:0], opcode};
            end
            F_I: begin
                reg_bad  = (|rd_b[7:5]) || (|rs1_b[7:5]);
                enc_word = {imm[11:0], rs1_b[4:0], f3, rd_b[4:0], opcode};
            end
            F_SH: begin
                reg_bad  = (|rd_b[7:5]) || (|rs1_b[7:5]);
                enc_word = {f7, imm[4:0], rs1_b[4:0], f3, rd_b[4:0], opcode};
            end
            F_S: begin
                reg_bad  = (|rs1_b[7:5]) || (|rs2_b[7:5]);
                enc_word = {imm[11:5], rs2_b[4:0], rs1_b[4:0], f3, imm[4:0], opcode};
            end
            F_B: begin
                reg_bad  = (|rs1_b[7:5]) || (|rs2_b[7:5]);
                enc_word = {imm[12], imm[10:5], rs2_b[4:0], rs1_b[4:0], f3,
                            imm[4:1], imm[11], opcode};
            end
            F_U: begin
                reg_bad  = |rd_b[7:5];
                enc_word = {imm[31:12], rd_b[4:0], opcode};
            end
            default: begin
                reg_bad  = |rd_b[7:5];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_b[4:0], opcode};
            end
        endcase
    end

    // Output word is registered during ENCODE and held through OUTPUT
    always_ff @(posedge clock) begin
        if (reset) begin
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (state == ENCODE) begin
            out_err   <= !known || reg_bad;
            out_instr <= (!known || reg_bad) ? NOP_WORD : enc_word;
        end
    end

endmodule

// File: tb/tb_instruction_encode_serial.sv
// tb_instruction_encode_serial
// Self-checking bench for instruction_encode_serial: table-driven directed
// vectors, hand-written multi-cycle sequences (latency, stall, reset), and
// random frames checked against a format-table reference model.
module tb_instruction_encode_serial;

    localparam logic [31:0] NOP = 32'h00000013;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    always #5 clock = ~clock;

    instruction_encode_serial #(.NOP_WORD(NOP)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // fmt: 0=R 1=I 2=shift-imm 3=S 4=B 5=U 6=J
    typedef struct {
        int fmt;
        int op;
        int f3;
        int f7;
    } ent_t;
    ent_t tbl[string];

    task automatic init_tbl();
        tbl["ADD"]  = '{0, 'h33, 0, 0};    tbl["SUB"]  = '{0, 'h33, 0, 'h20};
        tbl["SLL"]  = '{0, 'h33, 1, 0};    tbl["SLT"]  = '{0, 'h33, 2, 0};
        tbl["SLTU"] = '{0, 'h33, 3, 0};    tbl["XOR"]  = '{0, 'h33, 4, 0};
        tbl["SRL"]  = '{0, 'h33, 5, 0};    tbl["SRA"]  = '{0, 'h33, 5, 'h20};
        tbl["OR"]   = '{0, 'h33, 6, 0};    tbl["AND"]  = '{0, 'h33, 7, 0};
        tbl["ADDI"] = '{1, 'h13, 0, 0};    tbl["SLTI"] = '{1, 'h13, 2, 0};
        tbl["SLTIU"] = '{1, 'h13, 3, 0};   tbl["XORI"] = '{1, 'h13, 4, 0};
        tbl["ORI"]  = '{1, 'h13, 6, 0};    tbl["ANDI"] = '{1, 'h13, 7, 0};
        tbl["SLLI"] = '{2, 'h13, 1, 0};    tbl["SRLI"] = '{2, 'h13, 5, 0};
        tbl["SRAI"] = '{2, 'h13, 5, 'h20};
        tbl["LB"]   = '{1, 'h03, 0, 0};    tbl["LH"]   = '{1, 'h03, 1, 0};
        tbl["LW"]   = '{1, 'h03, 2, 0};    tbl["LBU"]  = '{1, 'h03, 4, 0};
        tbl["LHU"]  = '{1, 'h03, 5, 0};    tbl["JALR"] = '{1, 'h67, 0, 0};
        tbl["SB"]   = '{3, 'h23, 0, 0};    tbl["SH"]   = '{3, 'h23, 1, 0};
        tbl["SW"]   = '{3, 'h23, 2, 0};
        tbl["BEQ"]  = '{4, 'h63, 0, 0};    tbl["BNE"]  = '{4, 'h63, 1, 0};
        tbl["BLT"]  = '{4, 'h63, 4, 0};    tbl["BGE"]  = '{4, 'h63, 5, 0};
        tbl["BLTU"] = '{4, 'h63, 6, 0};    tbl["BGEU"] = '{4, 'h63, 7, 0};
        tbl["LUI"]  = '{5, 'h37, 0, 0};    tbl["AUIPC"] = '{5, 'h17, 0, 0};
        tbl["JAL"]  = '{6, 'h6F, 0, 0};
    endtask

    function automatic logic [32:0] model(input string name, input logic [7:0] rdb,
                                          input logic [7:0] rs1b, input logic [7:0] rs2b,
                                          input logic [31:0] imm);
        ent_t e;
        bit [31:0] w;
        bit [31:0] rd;
        bit [31:0] rs1;
        bit [31:0] rs2;
        bit use_rd;
        bit use_rs1;
        bit use_rs2;
        if (!tbl.exists(name)) return {1'b1, NOP};
        e = tbl[name];
        use_rd  = !(e.fmt == 3 || e.fmt == 4);
        use_rs1 = !(e.fmt == 5 || e.fmt == 6);
        use_rs2 = (e.fmt == 0 || e.fmt == 3 || e.fmt == 4);
        if ((use_rd && rdb > 31) || (use_rs1 && rs1b > 31) || (use_rs2 && rs2b > 31))
            return {1'b1, NOP};
        rd  = 32'(rdb & 8'h1F);
        rs1 = 32'(rs1b & 8'h1F);
        rs2 = 32'(rs2b & 8'h1F);
        w = 32'(e.op);
        case (e.fmt)
            0: w += (32'(e.f7) << 25) + (rs2 << 20) + (rs1 << 15) + (32'(e.f3) << 12) + (rd << 7);
            1: w += ((imm & 32'hFFF) << 20) + (rs1 << 15) + (32'(e.f3) << 12) + (rd << 7);
            2: w += (32'(e.f7) << 25) + ((imm & 32'h1F) << 20) + (rs1 << 15)
                    + (32'(e.f3) << 12) + (rd << 7);
            3: w += (((imm >> 5) & 32'h7F) << 25) + (rs2 << 20) + (rs1 << 15)
                    + (32'(e.f3) << 12) + ((imm & 32'h1F) << 7);
            4: w += (((imm >> 12) & 1) << 31) + (((imm >> 5) & 32'h3F) << 25) + (rs2 << 20)
                    + (rs1 << 15) + (32'(e.f3) << 12) + (((imm >> 1) & 32'hF) << 8)
                    + (((imm >> 11) & 1) << 7);
            5: w += (imm & 32'hFFFFF000) + (rd << 7);
            default: w += (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3FF) << 21)
                          + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 32'hFF) << 12) + (rd << 7);
        endcase
        return {1'b0, w};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic build(input string name, input logic [7:0] rdb, input logic [7:0] rs1b,
                         input logic [7:0] rs2b, input logic [31:0] imm,
                         output logic [7:0] b[12]);
        for (int i = 0; i < 5; i++) b[i] = (i < name.len()) ? name[i] : 8'h20;
        b[5] = rdb;
        b[6] = rs1b;
        b[7] = rs2b;
        for (int i = 0; i < 4; i++) b[8+i] = imm[8*i +: 8];
    endtask

    // Drives one frame; returns #1 after the edge that accepts the last byte
    task automatic send_frame(input logic [7:0] b[12], input int gap_pct);
        int  waits;
        bit  accepted;
        for (int i = 0; i < 12; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_byte  = b[i];
            accepted = 1'b0;
            waits    = 0;
            while (!accepted && waits < 40) begin
                accepted = in_ready;
                @(posedge clock); #1;
                waits++;
            end
            if (!accepted) begin
                check("in_ready timeout", 33'd0, 33'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Waits for a word, optionally stalls with junk on the input, consumes it
    task automatic recv_word(input string name, input int stall, input bit junk);
        int          waits;
        logic [32:0] got;
        logic [32:0] exp;
        waits = 0;
        while (!out_valid && waits < 40) begin
            @(posedge clock); #1;
            waits++;
        end
        exp = exp_q.pop_front();
        if (!out_valid) begin
            check({name, " out_valid timeout"}, 33'd0, 33'd1);
            return;
        end
        got = {out_err, out_instr};
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = junk;
            in_byte   = 8'($urandom);
            @(posedge clock); #1;
            check({name, " stall hold"}, {out_valid, in_ready, out_err, out_instr},
                  {1'b1, 1'b0, got});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check(name, got, exp);
        check({name, " released"}, {32'd0, out_valid}, 33'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [7:0]  rd;
        logic [7:0]  rs1;
        logic [7:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    string rand_names[$] = '{"ADD", "SUB", "SLL", "SLT", "SLTU", "XOR", "SRL", "SRA", "OR",
                             "AND", "ADDI", "SLTI", "SLTIU", "XORI", "ORI", "ANDI", "SLLI",
                             "SRLI", "SRAI", "LB", "LH", "LW", "LBU", "LHU", "JALR", "SB",
                             "SH", "SW", "BEQ", "BNE", "BLT", "BGE", "BLTU", "BGEU", "LUI",
                             "AUIPC", "JAL", "FOO", "ADDX", "LWU", "JALRX", "BEQZ"};

    initial begin
        logic [7:0]  b[12];
        logic [31:0] imm;
        logic [7:0]  r[3];
        string       nm;
        bit          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'd0;
        out_ready = 1'b0;
        init_tbl();

        vecs.push_back('{"addi",  8'd1, 8'd0,  8'd0,    32'hFFFFFFFF, 32'hFFF00093, 1'b0});
        vecs.push_back('{"SW",    8'd0, 8'd1,  8'd2,    32'h00000008, 32'h0020A423, 1'b0});
        vecs.push_back('{"BEQ",   8'd0, 8'd1,  8'd2,    32'h00000008, 32'h00208463, 1'b0});
        vecs.push_back('{"JAL",   8'd1, 8'd0,  8'd0,    32'h00000800, 32'h001000EF, 1'b0});
        vecs.push_back('{"LUI",   8'd5, 8'hFF, 8'hFF,   32'h12345000, 32'h123452B7, 1'b0});
        vecs.push_back('{"FOO",   8'd1, 8'd2,  8'd3,    32'h00000000, 32'h00000013, 1'b1});
        vecs.push_back('{"ADD",   8'h23, 8'd1, 8'd2,    32'h00000000, 32'h00000013, 1'b1});
        vecs.push_back('{"sra",   8'd1, 8'd2,  8'd3,    32'h00000000, 32'h403150B3, 1'b0});
        vecs.push_back('{"JAL",   8'd1, 8'd0,  8'd0,    32'h00000801, 32'h001000EF, 1'b0});
        vecs.push_back('{"SRAI",  8'd1, 8'd2,  8'd0,    32'hFFFFFFFF, 32'h41F15093, 1'b0});
        vecs.push_back('{"BNE",   8'd0, 8'd1,  8'd2,    32'hFFFFFFFE, 32'hFE209FE3, 1'b0});
        vecs.push_back('{"SW",    8'd0, 8'd1,  8'h20,   32'h00000000, 32'h00000013, 1'b1});
        vecs.push_back('{"LW",    8'd2, 8'd1,  8'hFF,   32'h00000004, 32'h0040A103, 1'b0});
        vecs.push_back('{"AUIPC", 8'd3, 8'd0,  8'd0,    32'hABCDE123, 32'hABCDE197, 1'b0});
        vecs.push_back('{"JALR",  8'd1, 8'd2,  8'd0,    32'h000007FF, 32'h7FF100E7, 1'b0});

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("reset state", {29'd0, in_ready, out_valid, out_err, out_instr == 32'd0},
              {29'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        check("reset out_instr", {1'b0, out_instr}, 33'd0);
        reset = 1'b0;

        // ADD with out_ready high in advance: latency and single-cycle consume
        build("ADD", 8'd3, 8'd1, 8'd2, 32'd0, b);
        out_ready = 1'b1;
        send_frame(b, 0);
        check("encode cycle", {31'd0, out_valid, in_ready}, 33'd0);
        @(posedge clock); #1;
        check("add valid", {32'd0, out_valid}, 33'd1);
        check("add word", {out_err, out_instr}, {1'b0, 32'h002081B3});
        @(posedge clock); #1;
        check("add consumed", {31'd0, out_valid, in_ready}, 33'd1);
        out_ready = 1'b0;

        // Directed table, with gaps, stalls and junk input during OUTPUT
        foreach (vecs[i]) begin
            build(vecs[i].name, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, b);
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_instr});
            send_frame(b, (i % 2) ? 30 : 0);
            recv_word($sformatf("vec%0d %s", i, vecs[i].name), i % 4, i[0]);
        end

        // Reset after 7 bytes, then a clean SLLI frame
        build("ADD", 8'd3, 8'd1, 8'd2, 32'd0, b);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_byte  = b[i];
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset    = 1'b0;
        check("mid-frame reset", {31'd0, in_ready, out_valid}, 33'd2);
        build("SLLI", 8'd2, 8'd2, 8'd0, 32'd3, b);
        exp_q.push_back({1'b0, 32'h00311113});
        send_frame(b, 0);
        recv_word("slli after reset", 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            seen |= out_valid;
        end
        check("no stale word", {32'd0, seen}, 33'd0);

        // Reset while a word is pending in OUTPUT discards it
        build("OR", 8'd1, 8'd1, 8'd1, 32'd0, b);
        send_frame(b, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("output reset", {out_err, out_instr, out_valid} , 34'd0 >> 1);

        // Random frames against the reference model
        for (int n = 0; n < 40; n++) begin
            nm  = rand_names[$urandom_range(rand_names.size() - 1)];
            imm = $urandom;
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(31));
            build(nm, r[0], r[1], r[2], imm, b);
            for (int k = 0; k < 5; k++)
                if (b[k] >= 8'h41 && b[k] <= 8'h5A && $urandom_range(1) == 1) b[k] |= 8'h20;
            exp_q.push_back(model(nm, r[0], r[1], r[2], imm));
            send_frame(b, $urandom_range(40));
            recv_word($sformatf("rand%0d %s", n, nm), $urandom_range(2), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
